// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and the iteration-counter width helper.
package div_pkg;

  // Default operand / quotient / remainder width (dividend is twice this).
  localparam int DIV_W = 32;

  // Iteration counter width for the default width.
  localparam int DIV_CNT_W = $clog2(DIV_W);

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Counter width able to index WIDTH iterations; never narrower than one bit.
  function automatic int div_cnt_width(input int width);
    if (width > 1) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the difference only
// when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pr,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] pr_next,
  output logic             q_bit
);

  // The shifted value can reach 2^(WIDTH+1)-1, so compare/subtract is WIDTH+1 wide.
  logic [WIDTH:0] trial_s;
  logic [WIDTH:0] divisor_ext_s;

  // Trial subtraction and restore decision.
  always_comb begin
    trial_s       = {pr, q_msb};
    divisor_ext_s = {1'b0, divisor};
    pr_next       = {WIDTH{1'b0}};
    q_bit         = 1'b0;
    if (trial_s >= divisor_ext_s) begin
      // Difference is below the divisor, so it always fits WIDTH bits.
      pr_next = WIDTH'(trial_s - divisor_ext_s);
      q_bit   = 1'b1;
    end else begin
      // No subtraction: trial is below the divisor, its top bit is zero.
      pr_next = trial_s[WIDTH-1:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/div64by32_seq.sv
// Sequential unsigned divider, 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Restoring algorithm, one quotient bit per cycle. Divide-by-zero and
// quotient overflow are detected at acceptance and answered in one cycle.
module div64by32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               dz,
  output logic               ovf
);

  localparam int               CNT_W    = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state_r;
  div_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;

  // Between iterations the partial remainder is always below the divisor,
  // so WIDTH bits suffice here; only the trial value inside the step needs
  // the extra bit.
  logic [WIDTH-1:0] pr_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] divisor_r;

  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dz_r;
  logic             ovf_r;

  logic [WIDTH-1:0] step_pr_s;
  logic             step_bit_s;
  logic             zero_div_s;
  logic             ovf_det_s;
  logic             last_step_s;

  assign zero_div_s  = (divisor == {WIDTH{1'b0}});
  assign ovf_det_s   = (dividend[2*WIDTH-1:WIDTH] >= divisor);
  assign last_step_s = (cnt_r == LAST_CNT);

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .pr      (pr_r),
    .q_msb   (q_r[WIDTH-1]),
    .divisor (divisor_r),
    .pr_next (step_pr_s),
    .q_bit   (step_bit_s)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; fast-path results go straight to DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (zero_div_s || ovf_det_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_step_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r       <= {CNT_W{1'b0}};
      pr_r        <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      divisor_r   <= {WIDTH{1'b0}};
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dz_r        <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            divisor_r <= divisor;
            cnt_r     <= {CNT_W{1'b0}};
            if (zero_div_s) begin
              quotient_r  <= {WIDTH{1'b1}};
              remainder_r <= dividend[WIDTH-1:0];
              dz_r        <= 1'b1;
              ovf_r       <= 1'b0;
            end else if (ovf_det_s) begin
              quotient_r  <= {WIDTH{1'b1}};
              remainder_r <= {WIDTH{1'b0}};
              dz_r        <= 1'b0;
              ovf_r       <= 1'b1;
            end else begin
              pr_r <= dividend[2*WIDTH-1:WIDTH];
              q_r  <= dividend[WIDTH-1:0];
            end
          end
        end
        RUN: begin
          pr_r  <= step_pr_s;
          q_r   <= {q_r[WIDTH-2:0], step_bit_s};
          cnt_r <= cnt_r + CNT_ONE;
          if (last_step_s) begin
            quotient_r  <= {q_r[WIDTH-2:0], step_bit_s};
            remainder_r <= step_pr_s;
            dz_r        <= 1'b0;
            ovf_r       <= 1'b0;
          end
        end
        DONE: begin
          // Results hold until the consumer takes them.
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Handshake flags are pure state decodes, no path from in_valid.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign dz        = dz_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_div64by32_seq.sv
// Directed bench for div64by32_seq: vector table plus handshake-hold and
// mid-run reset sequences.
module tb_div64by32_seq;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        dz;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ovf;
    int          lat;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  div64by32_seq #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz),
    .ovf       (ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Accept one operation and wait (bounded) for out_valid; lat counts edges after acceptance.
  task automatic run_op(input logic [63:0] a, input logic [31:0] b, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    dividend = 64'd0;
    divisor  = 32'd0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_after_hs", {63'd0, out_valid}, 64'd0);
    chk("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int lat;
    logic [63:0] recon;

    vecs[0]  = '{64'h0000_0000_0000_0064, 32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 32};
    vecs[1]  = '{64'h0000_0005_FFFF_FFFF, 32'd6,          32'hFFFF_FFFF,  32'd5,          1'b0, 1'b0, 32};
    vecs[2]  = '{64'h1234_5678_9ABC_DEF0, 32'd0,          32'hFFFF_FFFF,  32'h9ABC_DEF0,  1'b1, 1'b0, 0};
    vecs[3]  = '{64'h0000_0007_0000_0000, 32'd7,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b1, 0};
    vecs[4]  = '{64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 32};
    vecs[5]  = '{64'h0000_0001_0000_0000, 32'd2,          32'h8000_0000,  32'd0,          1'b0, 1'b0, 32};
    vecs[6]  = '{64'h0000_0000_FFFF_FFFF, 32'h10,         32'h0FFF_FFFF,  32'hF,          1'b0, 1'b0, 32};
    vecs[7]  = '{64'h0000_0000_0000_0000, 32'd5,          32'd0,          32'd0,          1'b0, 1'b0, 32};
    vecs[8]  = '{64'h0000_0003_0000_0005, 32'd3,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b1, 0};
    vecs[9]  = '{64'h1234_5678_9ABC_DEF0, 32'hFFFF_FFFF,  32'h1234_5678,  32'hACF1_3568,  1'b0, 1'b0, 32};
    vecs[10] = '{64'h0000_0000_DEAD_BEEF, 32'd1,          32'hDEAD_BEEF,  32'd0,          1'b0, 1'b0, 32};
    vecs[11] = '{64'h0000_0000_0000_0000, 32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 0};

    RST       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 64'd0;
    divisor   = 32'd0;
    repeat (3) step();

    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_quotient",  {32'd0, quotient},  64'd0);
    chk("rst_remainder", {32'd0, remainder}, 64'd0);
    chk("rst_dz",        {63'd0, dz},        64'd0);
    chk("rst_ovf",       {63'd0, ovf},       64'd0);
    RST = 1'b0;
    step();

    // Table-driven vectors.
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, lat);
      chk($sformatf("v%0d_quotient", i),  {32'd0, quotient},  {32'd0, vecs[i].q});
      chk($sformatf("v%0d_remainder", i), {32'd0, remainder}, {32'd0, vecs[i].r});
      chk($sformatf("v%0d_dz", i),        {63'd0, dz},        {63'd0, vecs[i].dz});
      chk($sformatf("v%0d_ovf", i),       {63'd0, ovf},       {63'd0, vecs[i].ovf});
      chk($sformatf("v%0d_latency", i),   64'(lat),           64'(vecs[i].lat));
      if (!vecs[i].dz && !vecs[i].ovf) begin
        recon = ({32'd0, vecs[i].q} * {32'd0, vecs[i].dvs}) + {32'd0, vecs[i].r};
        chk($sformatf("v%0d_invariant", i),
            ({32'd0, quotient} * {32'd0, vecs[i].dvs}) + {32'd0, remainder}, recon);
      end
      handshake();
    end

    // Hold: result stays stable with out_ready low; new in_valid ignored.
    run_op(64'h0000_0000_0000_0064, 32'd7, lat);
    chk("hold_latency", 64'(lat), 64'd32);
    dividend = 64'h0000_0007_0000_0000;
    divisor  = 32'd7;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_in_ready",  {63'd0, in_ready},  64'd0);
      chk("hold_quotient",  {32'd0, quotient},  64'd14);
      chk("hold_remainder", {32'd0, remainder}, 64'd2);
      chk("hold_ovf",       {63'd0, ovf},       64'd0);
    end
    handshake();
    chk("idle_retains_quotient", {32'd0, quotient}, 64'd14);
    step();
    in_valid = 1'b0;
    chk("next_accept_valid", {63'd0, out_valid}, 64'd1);
    chk("next_accept_ovf",   {63'd0, ovf},       64'd1);
    chk("next_accept_q",     {32'd0, quotient},  64'hFFFF_FFFF);
    handshake();

    // Reset in the middle of RUN at count 16.
    dividend = 64'h0000_0000_0000_0064;
    divisor  = 32'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (16) step();
    chk("pre_rst_running", {63'd0, in_ready}, 64'd0);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_quotient",  {32'd0, quotient},  64'd0);
    chk("arst_remainder", {32'd0, remainder}, 64'd0);
    chk("arst_dz",        {63'd0, dz},        64'd0);
    chk("arst_ovf",       {63'd0, ovf},       64'd0);
    repeat (3) step();
    RST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("post_rst_no_valid", {63'd0, out_valid}, 64'd0);
    end
    run_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, lat);
    chk("post_rst_latency",   64'(lat),           64'd32);
    chk("post_rst_quotient",  {32'd0, quotient},  64'hFFFF_FFFF);
    chk("post_rst_remainder", {32'd0, remainder}, 64'd0);
    chk("post_rst_dz",        {63'd0, dz},        64'd0);
    chk("post_rst_ovf",       {63'd0, ovf},       64'd0);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
